// File: rtl/view_pose_scheduler.sv
// Pose shadow buffer between game logic and the mode-7 renderer: sanitises
// incoming pose updates and commits them once per frame at a fixed raster point.
module view_pose_scheduler #(
    parameter logic [10:0] COMMIT_H     = 11'd0,
    parameter logic [9:0]  COMMIT_V     = 10'd768,
    parameter logic [10:0] MAX_COORD    = 11'd1983,
    parameter logic [10:0] RESET_PX     = 11'd1024,
    parameter logic [10:0] RESET_PY     = 11'd1024,
    parameter logic [10:0] RESET_OX     = 11'd1024,
    parameter logic [10:0] RESET_OY     = 11'd1024,
    parameter logic [7:0]  STALE_FRAMES = 8'd4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        upd_valid_in,
    output logic        upd_ready_out,
    input  logic [8:0]  upd_direction_in,
    input  logic [10:0] upd_player_x_in,
    input  logic [10:0] upd_player_y_in,
    input  logic [10:0] upd_opponent_x_in,
    input  logic [10:0] upd_opponent_y_in,
    output logic [8:0]  direction_out,
    output logic [10:0] player_x_out,
    output logic [10:0] player_y_out,
    output logic [10:0] opponent_x_out,
    output logic [10:0] opponent_y_out,
    output logic        frame_start_out,
    output logic        commit_out,
    output logic        stale_out
);

    // Handshake: an update transfers on a rising clk_in edge where
    // upd_valid_in && upd_ready_out; ready is low for the whole PENDING period.
    typedef enum logic {IDLE, PENDING} state_t;

    state_t      state, state_next;
    logic        boundary, boundary_q, boundary_edge;
    logic        capture, do_commit;
    logic [7:0]  stale_cnt, stale_cnt_next;
    logic [8:0]  sh_dir;
    logic [10:0] sh_px, sh_py, sh_ox, sh_oy;

    function automatic logic [10:0] clamp_coord(input logic [10:0] v);
        return (v > MAX_COORD) ? MAX_COORD : v;
    endfunction

    function automatic logic [8:0] wrap_dir(input logic [8:0] d);
        return (d >= 9'd360) ? (d - 9'd360) : d;
    endfunction

    assign boundary      = (hcount_in == COMMIT_H) && (vcount_in == COMMIT_V);
    // A frozen raster holds the boundary; only its first cycle is a frame event.
    assign boundary_edge = boundary && !boundary_q;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        do_commit  = 1'b0;
        case (state)
            IDLE: begin
                if (upd_valid_in) begin
                    capture    = 1'b1;
                    state_next = PENDING;
                end
            end
            PENDING: begin
                if (boundary_edge) begin
                    do_commit  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stale_cnt_next = stale_cnt;
        if (do_commit) begin
            stale_cnt_next = 8'd0;
        end else if (boundary_edge && stale_cnt != 8'hff) begin
            stale_cnt_next = stale_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            boundary_q      <= 1'b0;
            upd_ready_out   <= 1'b1;
            stale_cnt       <= 8'd0;
            stale_out       <= 1'b0;
            frame_start_out <= 1'b0;
            commit_out      <= 1'b0;
            sh_dir          <= 9'd0;
            sh_px           <= RESET_PX;
            sh_py           <= RESET_PY;
            sh_ox           <= RESET_OX;
            sh_oy           <= RESET_OY;
            direction_out   <= 9'd0;
            player_x_out    <= RESET_PX;
            player_y_out    <= RESET_PY;
            opponent_x_out  <= RESET_OX;
            opponent_y_out  <= RESET_OY;
        end else begin
            state           <= state_next;
            boundary_q      <= boundary;
            upd_ready_out   <= (state_next == IDLE);
            stale_cnt       <= stale_cnt_next;
            stale_out       <= (stale_cnt_next >= STALE_FRAMES);
            frame_start_out <= boundary_edge;
            commit_out      <= do_commit;
            if (capture) begin
                sh_dir <= wrap_dir(upd_direction_in);
                sh_px  <= clamp_coord(upd_player_x_in);
                sh_py  <= clamp_coord(upd_player_y_in);
                sh_ox  <= clamp_coord(upd_opponent_x_in);
                sh_oy  <= clamp_coord(upd_opponent_y_in);
            end
            if (do_commit) begin
                direction_out  <= sh_dir;
                player_x_out   <= sh_px;
                player_y_out   <= sh_py;
                opponent_x_out <= sh_ox;
                opponent_y_out <= sh_oy;
            end
        end
    end

endmodule

// File: tb/tb_view_pose_scheduler.sv
// Randomised and directed bench for view_pose_scheduler, checked every cycle
// against a frame-level pose model kept in the bench.
module tb_view_pose_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        upd_valid;
    logic        upd_ready;
    logic [8:0]  upd_dir;
    logic [10:0] upd_px, upd_py, upd_ox, upd_oy;
    logic [8:0]  direction;
    logic [10:0] player_x, player_y, opponent_x, opponent_y;
    logic        frame_start, commit, stale;

    always #5 clk = ~clk;

    view_pose_scheduler dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .hcount_in         (hcount),
        .vcount_in         (vcount),
        .upd_valid_in      (upd_valid),
        .upd_ready_out     (upd_ready),
        .upd_direction_in  (upd_dir),
        .upd_player_x_in   (upd_px),
        .upd_player_y_in   (upd_py),
        .upd_opponent_x_in (upd_ox),
        .upd_opponent_y_in (upd_oy),
        .direction_out     (direction),
        .player_x_out      (player_x),
        .player_y_out      (player_y),
        .opponent_x_out    (opponent_x),
        .opponent_y_out    (opponent_y),
        .frame_start_out   (frame_start),
        .commit_out        (commit),
        .stale_out         (stale)
    );

    int total = 0;
    int bad   = 0;
    int fs_cnt = 0;
    int cm_cnt = 0;

    // Frame-level model: a pending pose (if any), the pose the renderer sees,
    // and the number of frames since the last commit.
    bit m_pending;
    int m_sh[5];
    int m_out[5];
    int m_frames_since;
    bit m_prev_bnd;
    bit m_ready, m_fs, m_cm, m_stale;
    logic [52:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > 1983) ? 1983 : v;
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_sh  = '{0, 1024, 1024, 1024, 1024};
        m_out = '{0, 1024, 1024, 1024, 1024};
        m_frames_since = 0;
        m_prev_bnd = 0;
        m_ready = 1; m_fs = 0; m_cm = 0; m_stale = 0;
        exp_q.delete();
    endtask

    // Predicts what the outputs show after the coming clock edge.
    task automatic model_step();
        bit bnd, new_frame, was_pending;
        if (rst) begin
            model_reset();
            return;
        end
        bnd = (hcount == 11'd0) && (vcount == 10'd768);
        new_frame = bnd && !m_prev_bnd;
        was_pending = m_pending;
        m_fs = new_frame;
        m_cm = new_frame && was_pending;
        if (m_cm) begin
            m_out = m_sh;
            m_pending = 0;
            m_frames_since = 0;
            exp_q.push_back({9'(m_out[0]), 11'(m_out[1]), 11'(m_out[2]), 11'(m_out[3]), 11'(m_out[4])});
        end else if (new_frame) begin
            m_frames_since = (m_frames_since < 255) ? m_frames_since + 1 : 255;
        end
        m_stale = (m_frames_since >= 4);
        if (!was_pending && upd_valid) begin
            m_sh[0] = int'(upd_dir) % 360;
            m_sh[1] = clamp(int'(upd_px));
            m_sh[2] = clamp(int'(upd_py));
            m_sh[3] = clamp(int'(upd_ox));
            m_sh[4] = clamp(int'(upd_oy));
            m_pending = 1;
        end
        m_ready = !m_pending;
        m_prev_bnd = bnd;
    endtask

    task automatic compare();
        logic [52:0] e;
        chk("ready", 32'(upd_ready), 32'(m_ready));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("commit", 32'(commit), 32'(m_cm));
        chk("stale", 32'(stale), 32'(m_stale));
        chk("direction", 32'(direction), 32'(m_out[0]));
        chk("player_x", 32'(player_x), 32'(m_out[1]));
        chk("player_y", 32'(player_y), 32'(m_out[2]));
        chk("opponent_x", 32'(opponent_x), 32'(m_out[3]));
        chk("opponent_y", 32'(opponent_y), 32'(m_out[4]));
        if (commit === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("commit_unexpected", 32'(commit), 32'd0);
            end else begin
                e = exp_q.pop_front();
                total++;
                if ({direction, player_x, player_y, opponent_x, opponent_y} !== e) begin
                    bad++;
                    $display("FAIL commit_pose: got %h expected %h",
                             {direction, player_x, player_y, opponent_x, opponent_y}, e);
                end
            end
        end
        exp_q.delete();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare();
        if (frame_start === 1'b1) fs_cnt++;
        if (commit === 1'b1) cm_cnt++;
    endtask

    task automatic set_nonboundary();
        hcount = 11'($urandom_range(0, 1343));
        vcount = 10'($urandom_range(0, 805));
        if (hcount == 11'd0 && vcount == 10'd768) vcount = 10'd100;
    endtask

    task automatic idle(input int n);
        upd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            set_nonboundary();
            tick();
        end
    endtask

    task automatic boundary(input int n);
        upd_valid = 1'b0;
        hcount = 11'd0;
        vcount = 10'd768;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input int d, input int px, input int py, input int ox, input int oy);
        hcount = 11'd5;
        vcount = 10'd100;
        upd_valid = 1'b1;
        upd_dir = 9'(d);
        upd_px = 11'(px); upd_py = 11'(py); upd_ox = 11'(ox); upd_oy = 11'(oy);
        tick();
        upd_valid = 1'b0;
    endtask

    function automatic logic [10:0] rand_coord();
        return ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1980, 2047))
                                           : 11'($urandom_range(0, 2047));
    endfunction

    initial begin
        int hold;
        model_reset();
        rst = 1'b1;
        upd_valid = 1'b0;
        upd_dir = '0; upd_px = '0; upd_py = '0; upd_ox = '0; upd_oy = '0;
        hcount = 11'd5;
        vcount = 10'd100;
        tick();
        rst = 1'b0;
        chk("rst_direction", 32'(direction), 32'd0);
        chk("rst_player_x", 32'(player_x), 32'd1024);
        chk("rst_opponent_y", 32'(opponent_y), 32'd1024);
        chk("rst_ready", 32'(upd_ready), 32'd1);
        chk("rst_stale", 32'(stale), 32'd0);

        // Three idle frames: three frame pulses, no commits.
        fs_cnt = 0; cm_cnt = 0;
        for (int f = 0; f < 3; f++) begin
            idle(10);
            boundary(1);
        end
        idle(2);
        chk("idle_frames", 32'(fs_cnt), 32'd3);
        chk("idle_commits", 32'(cm_cnt), 32'd0);
        chk("idle_stale", 32'(stale), 32'd0);

        send(90, 500, 600, 700, 800);
        chk("ready_drop", 32'(upd_ready), 32'd0);
        idle(20);
        chk("held_direction", 32'(direction), 32'd0);
        boundary(1);
        chk("commit_dir90", 32'(direction), 32'd90);
        chk("commit_px500", 32'(player_x), 32'd500);
        chk("commit_oy800", 32'(opponent_y), 32'd800);
        chk("commit_pulse", 32'(commit), 32'd1);
        chk("commit_ready", 32'(upd_ready), 32'd1);

        send(400, 2047, 0, 5, 1990);
        idle(3);
        boundary(1);
        chk("wrap_400", 32'(direction), 32'd40);
        chk("clamp_px", 32'(player_x), 32'd1983);
        chk("clamp_oy", 32'(opponent_y), 32'd1983);
        chk("pass_py0", 32'(player_y), 32'd0);
        send(511, 1983, 1984, 0, 1);
        boundary(1);
        chk("wrap_511", 32'(direction), 32'd151);
        chk("clamp_1984", 32'(player_y), 32'd1983);

        // Handshake on the boundary cycle itself waits a frame.
        idle(2);
        hcount = 11'd0; vcount = 10'd768;
        upd_valid = 1'b1; upd_dir = 9'd10;
        upd_px = 11'd1; upd_py = 11'd2; upd_ox = 11'd3; upd_oy = 11'd4;
        tick();
        upd_valid = 1'b0;
        chk("bnd_hs_no_commit", 32'(commit), 32'd0);
        chk("bnd_hs_frame", 32'(frame_start), 32'd1);
        idle(3);
        boundary(1);
        chk("bnd_hs_next_commit", 32'(commit), 32'd1);
        chk("bnd_hs_dir10", 32'(direction), 32'd10);

        for (int i = 0; i < 4; i++) begin
            idle(2);
            boundary(1);
            if (i == 2) chk("stale_after3", 32'(stale), 32'd0);
        end
        chk("stale_after4", 32'(stale), 32'd1);
        send(1, 1, 1, 1, 1);
        boundary(1);
        chk("stale_cleared", 32'(stale), 32'd0);

        // Frozen raster: one frame event per contiguous boundary run.
        send(77, 10, 20, 30, 40);
        fs_cnt = 0;
        boundary(5);
        chk("frozen_frames", 32'(fs_cnt), 32'd1);
        chk("frozen_dir", 32'(direction), 32'd77);

        send(200, 9, 9, 9, 9);
        idle(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_dir", 32'(direction), 32'd0);
        chk("midrst_px", 32'(player_x), 32'd1024);
        chk("midrst_ready", 32'(upd_ready), 32'd1);
        idle(2);
        boundary(1);
        chk("midrst_no_commit", 32'(commit), 32'd0);

        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            upd_valid = ($urandom_range(0, 3) == 0);
            upd_dir = 9'($urandom_range(0, 511));
            upd_px = rand_coord(); upd_py = rand_coord();
            upd_ox = rand_coord(); upd_oy = rand_coord();
            if (hold > 0) begin
                hold--;
            end else if ($urandom_range(0, 24) == 0) begin
                hold = $urandom_range(0, 2);
                hcount = 11'd0;
                vcount = 10'd768;
            end else begin
                set_nonboundary();
            end
            tick();
        end
        rst = 1'b0;
        upd_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
